// File: rtl/md_pkg.sv
// Shared types and constants for the md_datapath multiply/divide unit.
package md_pkg;

    localparam int unsigned MD_WIDTH_DEFAULT = 26;

    // Sequencer states; DIV and FIX are only reachable when divide is built in.
    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } md_state_e;

    // Radix-4 Booth digit: sign plus magnitude in {0,1,2}.
    typedef struct packed {
        logic       neg;
        logic [1:0] mag;
    } booth_digit_t;

    // Recode multiplier bits (2i+1, 2i, 2i-1) into a signed digit.
    function automatic booth_digit_t booth_encode(input logic [2:0] bits);
        booth_digit_t d;
        d = '{neg: 1'b0, mag: 2'd0};
        case (bits)
            3'b001, 3'b010: d = '{neg: 1'b0, mag: 2'd1};
            3'b011:         d = '{neg: 1'b0, mag: 2'd2};
            3'b100:         d = '{neg: 1'b1, mag: 2'd2};
            3'b101, 3'b110: d = '{neg: 1'b1, mag: 2'd1};
            default:        d = '{neg: 1'b0, mag: 2'd0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/md_booth_recode.sv
// Combinational radix-4 Booth recoder: three multiplier bits to one digit.
module md_booth_recode
    import md_pkg::*;
(
    input  logic [2:0] i_bits,
    output logic       o_neg,
    output logic [1:0] o_mag
);

    booth_digit_t w_digit;

    assign w_digit = booth_encode(i_bits);
    assign o_neg   = w_digit.neg;
    assign o_mag   = w_digit.mag;

endmodule

// File: rtl/md_datapath.sv
// Signed multiply/divide unit: radix-4 Booth multiply, restoring divide on
// magnitudes with a trailing sign-fix cycle. Divide hardware is only built
// when MD_DIVIDE_EN is defined; otherwise divide requests report OVF.
module md_datapath
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_op_div,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplier,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_prod_hi,
    output logic [WIDTH-1:0] o_prod_lo,
    output logic             o_ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH / 2 - 1);

    md_state_e r_state;
    md_state_e w_state_next;

    // r_acc is the high half of the product; r_mplier shifts out multiplier
    // bits while product low bits shift in (dividend/quotient in divide).
    logic [WIDTH+1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_prod_hi;
    logic [WIDTH-1:0] r_prod_lo;
    logic             r_ovf;

    logic             w_out_load;
    logic [WIDTH-1:0] w_out_hi;
    logic [WIDTH-1:0] w_out_lo;
    logic             w_out_ovf;

    // Booth step
    logic [2:0]       w_booth_bits;
    logic             w_neg;
    logic [1:0]       w_mag;
    logic [WIDTH+1:0] w_mc_ext;
    logic [WIDTH+1:0] w_pp;
    logic [WIDTH+1:0] w_acc_sum;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;

    assign w_booth_bits = {r_mplier[1:0], r_prev};

    md_booth_recode u_booth (
        .i_bits (w_booth_bits),
        .o_neg  (w_neg),
        .o_mag  (w_mag)
    );

    assign w_mc_ext  = {{2{r_mcand[WIDTH-1]}}, r_mcand};
    assign w_pp      = (w_mag == 2'd2) ? (w_mc_ext << 1) :
                       (w_mag == 2'd1) ? w_mc_ext : '0;
    assign w_acc_sum = w_neg ? (r_acc - w_pp) : (r_acc + w_pp);
    // Arithmetic shift right by two of {acc_sum, mplier}.
    assign w_hi_next = w_acc_sum[WIDTH+1:2];
    assign w_lo_next = {w_acc_sum[1:0], r_mplier[WIDTH-1:2]};

`ifdef MD_DIVIDE_EN
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH - 1){1'b0}}};

    logic [WIDTH-1:0] r_rem;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_div_ovf;

    logic [WIDTH-1:0] w_mcand_abs;
    logic [WIDTH-1:0] w_mplier_abs;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Magnitudes are unsigned, so -2^(W-1) maps to 2^(W-1) without loss.
    assign w_mcand_abs  = i_mcand[WIDTH-1] ? -i_mcand : i_mcand;
    assign w_mplier_abs = i_mplier[WIDTH-1] ? -i_mplier : i_mplier;

    assign w_shift    = {r_rem, r_mplier[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_mcand});
    // When w_ge holds the true difference is below the divisor, so W bits suffice.
    assign w_diff     = w_shift[WIDTH-1:0] - r_mcand;
    assign w_rem_step = w_ge ? w_diff : w_shift[WIDTH-1:0];

    // Overflow case needs no special handling: 2^(W-1) unnegated wraps to MIN.
    assign w_quo_fix = r_q_neg ? -r_mplier : r_mplier;
    assign w_rem_fix = r_r_neg ? -r_rem : r_rem;
`endif

    // Next-state decode and selection of the values captured on DONE entry.
    always_comb begin
        w_state_next = r_state;
        w_out_load   = 1'b0;
        w_out_hi     = '0;
        w_out_lo     = '0;
        w_out_ovf    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (!i_op_div) begin
                        w_state_next = StMul;
`ifdef MD_DIVIDE_EN
                    end else if (i_mcand != '0) begin
                        w_state_next = StDiv;
                    end else begin
                        w_state_next = StDone;
                        w_out_load   = 1'b1;
                        w_out_lo     = i_mplier;
                        w_out_ovf    = 1'b1;
                    end
`else
                    end else begin
                        w_state_next = StDone;
                        w_out_load   = 1'b1;
                        w_out_ovf    = 1'b1;
                    end
`endif
                end
            end
            StMul: begin
                if (r_cnt == MUL_LAST) begin
                    w_state_next = StDone;
                    w_out_load   = 1'b1;
                    w_out_hi     = w_hi_next;
                    w_out_lo     = w_lo_next;
                end
            end
`ifdef MD_DIVIDE_EN
            StDiv: begin
                if (r_cnt == DIV_LAST) w_state_next = StFix;
            end
            StFix: begin
                w_state_next = StDone;
                w_out_load   = 1'b1;
                w_out_hi     = w_quo_fix;
                w_out_lo     = w_rem_fix;
                w_out_ovf    = r_div_ovf;
            end
`endif
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    // Operand staging, iteration datapath and result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prev    <= 1'b0;
            r_cnt     <= '0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
            r_ovf     <= 1'b0;
`ifdef MD_DIVIDE_EN
            r_rem     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_div_ovf <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_acc  <= '0;
                        r_prev <= 1'b0;
                        r_cnt  <= '0;
                        if (!i_op_div) begin
                            r_mcand  <= i_mcand;
                            r_mplier <= i_mplier;
                        end
`ifdef MD_DIVIDE_EN
                        else begin
                            r_mcand   <= w_mcand_abs;
                            r_mplier  <= w_mplier_abs;
                            r_rem     <= '0;
                            r_q_neg   <= i_mcand[WIDTH-1] ^ i_mplier[WIDTH-1];
                            r_r_neg   <= i_mplier[WIDTH-1];
                            r_div_ovf <= (i_mplier == MIN_VAL) && (i_mcand == '1);
                        end
`endif
                    end
                end
                StMul: begin
                    r_acc    <= {{2{w_hi_next[WIDTH-1]}}, w_hi_next};
                    r_mplier <= w_lo_next;
                    r_prev   <= r_mplier[1];
                    r_cnt    <= r_cnt + 1'b1;
                end
`ifdef MD_DIVIDE_EN
                StDiv: begin
                    r_rem    <= w_rem_step;
                    r_mplier <= {r_mplier[WIDTH-2:0], w_ge};
                    r_cnt    <= r_cnt + 1'b1;
                end
`endif
                default: ;
            endcase
            if (w_out_load) begin
                r_prod_hi <= w_out_hi;
                r_prod_lo <= w_out_lo;
                r_ovf     <= w_out_ovf;
            end
        end
    end

    assign o_busy    = (r_state != StIdle);
    assign o_done    = (r_state == StDone);
    assign o_prod_hi = r_prod_hi;
    assign o_prod_lo = r_prod_lo;
    assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_md_datapath.sv
// Self-checking bench for md_datapath (W=26). Divide expectations follow
// MD_DIVIDE_EN so the same bench covers both builds.
`timescale 1ns / 1ps
module tb_md_datapath;

    localparam int W = 26;
    localparam logic [W-1:0] MINV = 26'h2000000;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op_div;
    logic [W-1:0] mcand;
    logic [W-1:0] mplier;
    logic         busy;
    logic         done;
    logic [W-1:0] prod_hi;
    logic [W-1:0] prod_lo;
    logic         ovf;

    int n_tests = 0;
    int n_fail  = 0;

    md_datapath #(.WIDTH(W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_op_div  (op_div),
        .i_mcand   (mcand),
        .i_mplier  (mplier),
        .o_busy    (busy),
        .o_done    (done),
        .o_prod_hi (prod_hi),
        .o_prod_lo (prod_lo),
        .o_ovf     (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit           op_div;
        logic [W-1:0] mcand;
        logic [W-1:0] mplier;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           ovf;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model from arithmetic definitions, not the RTL's algorithm.
    task automatic model(input bit opd, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output bit ov, output int lat);
        longint sa;
        longint sb;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!opd) begin
            p   = sa * sb;
            hi  = W'(p >>> W);
            lo  = W'(p);
            ov  = 1'b0;
            lat = W / 2 + 1;
        end else begin
`ifdef MD_DIVIDE_EN
            if (sa == 0) begin
                hi = '0; lo = b; ov = 1'b1; lat = 1;
            end else begin
                hi  = W'(sb / sa);
                lo  = W'(sb % sa);
                ov  = (b == MINV) && (sa == -1);
                lat = W + 2;
            end
`else
            hi = '0; lo = '0; ov = 1'b1; lat = 1;
`endif
        end
    endtask

    // Issue one op (caller is 1ns after an edge, unit idle) and check it.
    task automatic run_check(input string tag, input bit opd, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] ehi,
                             input logic [W-1:0] elo, input bit eov, input int elat);
        int cyc;
        bit got;
        start = 1'b1; op_div = opd; mcand = a; mplier = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 60) begin
            if (done) begin
                got = 1'b1;
                chk({tag, "_lat"}, cyc, elat);
                chk({tag, "_hi"}, prod_hi, ehi);
                chk({tag, "_lo"}, prod_lo, elo);
                chk({tag, "_ovf"}, ovf, eov);
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!got) chk({tag, "_timeout"}, 0, 1);
        else      chk({tag, "_idle_after"}, {busy, done}, 0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        bit           eov;
        int           elat;
        int           ndone;
        int           cyc;

        rst = 1'b1; start = 1'b0; op_div = 1'b0; mcand = '0; mplier = '0;

        vecs.push_back('{1'b0, 26'h0000003, 26'h3FFFFFB, 26'h3FFFFFF, 26'h3FFFFF1, 1'b0, 14});
        vecs.push_back('{1'b0, 26'h2000000, 26'h2000000, 26'h1000000, 26'h0000000, 1'b0, 14});
        vecs.push_back('{1'b0, 26'h1FFFFFF, 26'h1FFFFFF, 26'h0FFFFFF, 26'h0000001, 1'b0, 14});
        vecs.push_back('{1'b0, 26'h3FFFFFF, 26'h3FFFFFF, 26'h0000000, 26'h0000001, 1'b0, 14});
        vecs.push_back('{1'b0, 26'h3FFFFFF, 26'h2000000, 26'h0000000, 26'h2000000, 1'b0, 14});
        vecs.push_back('{1'b0, 26'h0000000, 26'h1234567, 26'h0000000, 26'h0000000, 1'b0, 14});
`ifdef MD_DIVIDE_EN
        vecs.push_back('{1'b1, 26'h0000002, 26'h3FFFFF9, 26'h3FFFFFD, 26'h3FFFFFF, 1'b0, 28});
        vecs.push_back('{1'b1, 26'h0000000, 26'h0000005, 26'h0000000, 26'h0000005, 1'b1, 1});
        vecs.push_back('{1'b1, 26'h3FFFFFF, 26'h2000000, 26'h2000000, 26'h0000000, 1'b1, 28});
        vecs.push_back('{1'b1, 26'h3FFFFFE, 26'h0000007, 26'h3FFFFFD, 26'h0000001, 1'b0, 28});
        vecs.push_back('{1'b1, 26'h0000007, 26'h0000064, 26'h000000E, 26'h0000002, 1'b0, 28});
        vecs.push_back('{1'b1, 26'h0000001, 26'h2000000, 26'h2000000, 26'h0000000, 1'b0, 28});
`else
        vecs.push_back('{1'b1, 26'h0000002, 26'h3FFFFF9, 26'h0000000, 26'h0000000, 1'b1, 1});
        vecs.push_back('{1'b1, 26'h0000000, 26'h0000005, 26'h0000000, 26'h0000000, 1'b1, 1});
`endif
        // Multiply right after a divide request must still be correct.
        vecs.push_back('{1'b0, 26'h0000003, 26'h3FFFFFB, 26'h3FFFFFF, 26'h3FFFFF1, 1'b0, 14});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", prod_hi, 0);
        chk("rst_lo", prod_lo, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_check($sformatf("vec%0d", i), vecs[i].op_div, vecs[i].mcand,
                      vecs[i].mplier, vecs[i].hi, vecs[i].lo, vecs[i].ovf, vecs[i].lat);
        end

        // START during MUL (cycle 3) and in DONE (cycle 14) must be ignored.
        start = 1'b1; op_div = 1'b0; mcand = 26'h0000003; mplier = 26'h3FFFFFB;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            start = (c == 3 || c == 14);
            mcand = start ? 26'h0000007 : 26'h0000003;
            mplier = start ? 26'h0000007 : 26'h3FFFFFB;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    chk("ign_lat", c, 14);
                    chk("ign_hi", prod_hi, 26'h3FFFFFF);
                    chk("ign_lo", prod_lo, 26'h3FFFFF1);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("ign_ndone", ndone, 1);
        chk("ign_idle", busy, 0);

        // Asynchronous reset at cycle 5 of a multiply aborts it silently.
        start = 1'b1; op_div = 1'b0; mcand = 26'h1FFFFFF; mplier = 26'h1FFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc < 5; cyc++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_hi", prod_hi, 0);
        chk("arst_lo", prod_lo, 0);
        chk("arst_ovf", ovf, 0);
        #3 rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("arst_nodone", ndone, 0);
        chk("arst_idle", busy, 0);
        run_check("post_rst", 1'b0, 26'h0000003, 26'h3FFFFFB, 26'h3FFFFFF, 26'h3FFFFF1,
                  1'b0, 14);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            bit           opd;
            opd = 1'($urandom());
            a = W'($urandom());
            b = W'($urandom());
            case ($urandom_range(0, 7))
                0: a = '0;
                1: a = '1;
                2: b = MINV;
                3: a = W'($urandom_range(1, 9));
                4: begin a = '1; b = MINV; end
                default: ;
            endcase
            model(opd, a, b, ehi, elo, eov, elat);
            run_check($sformatf("rnd%0d", i), opd, a, b, ehi, elo, eov, elat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
